// File: rtl/network_div_sdiv_27s_11ns_16_seq.sv
// Sequential signed/unsigned divider: 27-bit signed dividend by 11-bit unsigned divisor.
// Restoring division on the dividend magnitude, 16-bit saturated quotient, signed remainder.
module network_div_sdiv_27s_11ns_16_seq #(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] dividend,
  input  logic [10:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [11:0] remainder,
  output logic        ovf,
  output logic        dbz
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready=1
  // CALC  | first cycle forms |dividend|, then 27 quotient bits MSB first
  // DONE  | result held until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] CNT_LOAD = 5'd28;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [26:0] work;
  logic [10:0] part;
  logic [10:0] div_r;
  logic        neg;

  logic [11:0] trial;
  logic [11:0] diff;
  logic        qbit;
  logic [10:0] part_nxt;
  logic [26:0] q_mag;
  logic [15:0] q_fin;
  logic [11:0] r_fin;
  logic        ovf_fin;
  logic        dz;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    trial    = {part, work[26]};
    diff     = trial - {1'b0, div_r};
    qbit     = (trial >= {1'b0, div_r});
    part_nxt = qbit ? diff[10:0] : trial[10:0];
    q_mag    = {work[25:0], qbit};
    dz       = (div_r == 11'd0);
    q_fin    = 16'd0;
    r_fin    = neg ? (12'd0 - {1'b0, part_nxt}) : {1'b0, part_nxt};
    ovf_fin  = 1'b0;
    if (dz) begin
      q_fin = neg ? 16'h8000 : 16'h7fff;
      r_fin = 12'd0;
    end else if (!neg) begin
      if (q_mag > 27'd32767) begin
        q_fin   = 16'h7fff;
        ovf_fin = 1'b1;
      end else begin
        q_fin = q_mag[15:0];
      end
    end else begin
      // -32768 is representable, so only magnitudes beyond 32768 saturate
      if (q_mag > 27'd32768) begin
        q_fin   = 16'h8000;
        ovf_fin = 1'b1;
      end else begin
        q_fin = 16'd0 - q_mag[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      work      <= 27'd0;
      part      <= 11'd0;
      div_r     <= 11'd0;
      neg       <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 12'd0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= dividend;
            div_r <= divisor;
            neg   <= dividend[26];
            part  <= 11'd0;
            cnt   <= CNT_LOAD;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == CNT_LOAD) begin
            // 27-bit unsigned negate keeps -2^26 exact
            work <= neg ? (27'd0 - work) : work;
          end else begin
            work <= q_mag;
            part <= part_nxt;
          end
          if (cnt == 5'd1) begin
            cnt       <= 5'd0;
            state     <= DONE;
            quotient  <= q_fin;
            remainder <= r_fin;
            ovf       <= ovf_fin;
            dbz       <= dz;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule
